// File: rtl/rr_packet_mux_arbiter_pkg.sv
// Shared types and sizes for the packet-aware round-robin mux arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_packet_mux_arbiter_if.sv
// Producer-side and consumer-side stream signals of the arbiter in one bundle.
interface rr_packet_mux_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ-1:0]       in_last;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic                   out_last;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;

  // Environment side: producers and consumer
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_id
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_id
  );

endinterface

// File: rtl/rr_packet_mux_arbiter_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping mod 4.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_any
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;

  // Rotate so ptr lands on bit 0, priority-encode the lowest bit, un-rotate
  always_comb begin
    rot = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      rot[i] = req[ptr + ID_W'(i)];
    end
    off = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    gnt_any = |rot;
    gnt_id  = ptr + off;
  end

endmodule

// File: rtl/rr_packet_mux_arbiter.sv
// Shares one registered output stream between 4 requesters; a granted
// requester keeps the channel until its last beat is accepted.
module rr_packet_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  rr_packet_mux_arbiter_if.slave  bus
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;

  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            free;
  logic            grant;
  logic [WIDTH-1:0] data_sel;
  logic            last_sel;

  rr_pick_4 u_pick (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  // While locked only the owner may be granted; others are ignored
  always_comb begin
    gnt_id  = pick_id;
    gnt_any = pick_any;
    if (state == ST_LOCKED) begin
      gnt_id  = owner;
      gnt_any = bus.in_valid[owner];
    end
    free         = ~bus.out_valid | bus.out_ready;
    grant        = ~rst & free & gnt_any;
    bus.in_ready = grant ? (N_REQ'(1) << gnt_id) : '0;
  end

  // 4:1 data/last select on the grant index
  always_comb begin
    data_sel = '0;
    case (gnt_id)
      2'd0:    data_sel = bus.in_data[0*WIDTH +: WIDTH];
      2'd1:    data_sel = bus.in_data[1*WIDTH +: WIDTH];
      2'd2:    data_sel = bus.in_data[2*WIDTH +: WIDTH];
      default: data_sel = bus.in_data[3*WIDTH +: WIDTH];
    endcase
    last_sel = bus.in_last[gnt_id];
  end

  // Arbitration state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else if (grant) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= data_sel;
      bus.out_last  <= last_sel;
      bus.out_id    <= gnt_id;
      owner         <= gnt_id;
      if (last_sel) begin
        state  <= ST_IDLE;
        rr_ptr <= gnt_id + ID_W'(1);
      end else begin
        state  <= ST_LOCKED;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_packet_mux_arbiter.sv
// Directed bench for rr_packet_mux_arbiter with hand-computed expectations.
module tb_rr_packet_mux_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_packet_mux_arbiter_if #(.WIDTH(4)) bus ();

  rr_packet_mux_arbiter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // req0=4, req1=7, req2=A, req3=D
  function automatic logic [3:0] req_data(input int id);
    case (id)
      0:       return 4'h4;
      1:       return 4'h7;
      2:       return 4'hA;
      default: return 4'hD;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after negedge, check in_ready, then pass the edge
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l,
                     input logic ordy, input logic [3:0] exp_rdy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic v, input int id, input logic last);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      check({tag, ".out_id"},   32'(bus.out_id),   32'(id));
      check({tag, ".out_data"}, 32'(bus.out_data), 32'(req_data(id)));
      check({tag, ".out_last"}, 32'(bus.out_last), 32'(last));
    end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = {4'hD, 4'hA, 4'h7, 4'h4};
    bus.out_ready = 1'b1;

    // Reset: no grants, cleared outputs
    rst = 1'b1;
    cyc("rst0", 4'b1111, 4'b1111, 1'b1, 4'b0000);
    cyc("rst1", 4'b1111, 4'b1111, 1'b1, 4'b0000);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_data",  32'(bus.out_data),  32'd0);
    check("rst.out_last",  32'(bus.out_last),  32'd0);
    check("rst.out_id",    32'(bus.out_id),    32'd0);
    rst = 1'b0;

    // 1: all requesting single beats -> 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t1_%0d", k), 4'b1111, 4'b1111, 1'b1, 4'(1 << (k % 4)));
      out_chk($sformatf("t1_%0d", k), 1'b1, k % 4, 1'b1);
    end

    // 2: req0 3-beat packet holds off req1 (rr_ptr=0)
    cyc("t2_b1", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    out_chk("t2_b1", 1'b1, 0, 1'b0);
    cyc("t2_b2", 4'b0011, 4'b0010, 1'b1, 4'b0001);
    out_chk("t2_b2", 1'b1, 0, 1'b0);
    cyc("t2_b3", 4'b0011, 4'b0011, 1'b1, 4'b0001);
    out_chk("t2_b3", 1'b1, 0, 1'b1);
    cyc("t2_r1", 4'b0010, 4'b0010, 1'b1, 4'b0010);
    out_chk("t2_r1", 1'b1, 1, 1'b1);

    // 3: rr_ptr=2, load A from req2, then stall 3 cycles
    cyc("t3_ld", 4'b0100, 4'b0100, 1'b1, 4'b0100);
    out_chk("t3_ld", 1'b1, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("t3_st%0d", k), 4'b1000, 4'b1000, 1'b0, 4'b0000);
      out_chk($sformatf("t3_st%0d", k), 1'b1, 2, 1'b1);
    end
    cyc("t3_rel", 4'b1000, 4'b1000, 1'b1, 4'b1000);
    out_chk("t3_rel", 1'b1, 3, 1'b1);

    // 4: rr_ptr=0, lock on req2, req2 bubbles two cycles while req3 waits
    cyc("t4_b1", 4'b0100, 4'b0000, 1'b1, 4'b0100);
    out_chk("t4_b1", 1'b1, 2, 1'b0);
    cyc("t4_gap0", 4'b1000, 4'b1000, 1'b1, 4'b0000);
    out_chk("t4_gap0", 1'b0, 0, 1'b0);
    cyc("t4_gap1", 4'b1000, 4'b1000, 1'b1, 4'b0000);
    out_chk("t4_gap1", 1'b0, 0, 1'b0);
    cyc("t4_b2", 4'b1100, 4'b1100, 1'b1, 4'b0100);
    out_chk("t4_b2", 1'b1, 2, 1'b1);

    // 5: rr_ptr=3, requests 1001 -> 3 then wrap to 0
    cyc("t5_a", 4'b1001, 4'b1001, 1'b1, 4'b1000);
    out_chk("t5_a", 1'b1, 3, 1'b1);
    cyc("t5_b", 4'b0001, 4'b0001, 1'b1, 4'b0001);
    out_chk("t5_b", 1'b1, 0, 1'b1);

    // 6: rr_ptr=1, lock on req1, reset mid-packet, restart from req0
    cyc("t6_lk", 4'b0010, 4'b0000, 1'b1, 4'b0010);
    out_chk("t6_lk", 1'b1, 1, 1'b0);
    rst = 1'b1;
    cyc("t6_rst", 4'b0010, 4'b0000, 1'b1, 4'b0000);
    out_chk("t6_rst", 1'b0, 0, 1'b0);
    rst = 1'b0;
    cyc("t6_g0", 4'b0011, 4'b0011, 1'b1, 4'b0001);
    out_chk("t6_g0", 1'b1, 0, 1'b1);
    cyc("t6_g1", 4'b0010, 4'b0010, 1'b1, 4'b0010);
    out_chk("t6_g1", 1'b1, 1, 1'b1);
    cyc("t6_idle", 4'b0000, 4'b0000, 1'b1, 4'b0000);
    out_chk("t6_idle", 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
